// File: rtl/sseg_pkg.sv
// sseg_pkg
//   Shared definitions for the seven-segment scan controller: the hex glyph
//   table, the blank and dash segment patterns, the nibble type, the
//   converter state type and a helper that sizes the BCD result.
//   Segment patterns are active-low {g,f,e,d,c,b,a}.
package sseg_pkg;

  typedef logic [3:0] nibble_t;

  typedef enum logic {
    CONV_IDLE  = 1'b0,
    CONV_SHIFT = 1'b1
  } conv_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Entry n is the glyph for hex digit n (entry F listed first).
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] glyph(input nibble_t n);
    return GLYPH_TABLE[n];
  endfunction

  // Decimal digits needed to hold any data_w-bit value (301/1000 ~ log10(2)),
  // never fewer than the number of displayed digits.
  function automatic int bcd_digits(input int data_w, input int min_digits);
    int d;
    d = (data_w * 301) / 1000 + 1;
    return (d > min_digits) ? d : min_digits;
  endfunction

endpackage

// File: rtl/sseg_bin2bcd.sv
// sseg_bin2bcd
//   Sequential binary-to-BCD converter (shift-add-3, one bit per cycle).
//   Only present in builds with SSEG_BCD_EN defined.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     start, bin      start a conversion of bin (ignored while busy)
//     busy            high for exactly DATA_W cycles after start is taken
//     done            high in the last busy cycle; bcd is valid then
//     bcd             conversion result, BCD_W bits
//
//   state      | meaning
//   CONV_IDLE  | waiting for start
//   CONV_SHIFT | one adjust+shift step per cycle, DATA_W steps
`ifdef SSEG_BCD_EN
module sseg_bin2bcd
  import sseg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BCD_W  = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] bin,
  output logic              busy,
  output logic              done,
  output logic [BCD_W-1:0]  bcd
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  conv_state_t       state_q, state_next;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] bin_q, bin_sh;
  logic [BCD_W-1:0]  bcd_q, bcd_adj, bcd_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CONV_IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_next;
      if (state_q == CONV_IDLE && start) begin
        bin_q <= bin;
        bcd_q <= '0;
        cnt_q <= CNT_W'(DATA_W - 1);
      end else if (state_q == CONV_SHIFT) begin
        bin_q <= bin_sh;
        bcd_q <= bcd_sh;
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_q;
    bcd_adj    = bcd_q;
    for (int d = 0; d < BCD_W / 4; d++)
      if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    {bcd_sh, bin_sh} = {bcd_adj, bin_q} << 1;
    case (state_q)
      CONV_IDLE:  if (start) state_next = CONV_SHIFT;
      CONV_SHIFT: if (cnt_q == '0) state_next = CONV_IDLE;
      default:    state_next = CONV_IDLE;
    endcase
  end

  // The final step's result is presented combinationally so the caller can
  // load it on the same edge busy falls.
  assign busy = (state_q == CONV_SHIFT);
  assign done = busy && (cnt_q == '0);
  assign bcd  = bcd_sh;

endmodule
`endif

// File: rtl/sseg_scan_controller.sv
// sseg_scan_controller
//   Time-multiplexed seven-segment display driver with optional leading-zero
//   blanking and per-digit decimal points.
//   Build option: SSEG_BCD_EN -- captures are converted to decimal by
//   sseg_bin2bcd and overflow shows dashes; otherwise the value is shown in
//   hex and busy/overflow are tied low.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     writeback     value to display; write_ready captures it when not busy
//     blank_en      leading-zero blanking enable
//     dp_mask       bit i lights the decimal point of digit i
//     SSEG_AN       active-low anode enables (registered)
//     SSEG_CA       active-low cathodes {dp,g,f,e,d,c,b,a} (registered)
//     busy          conversion in progress
//     overflow      displayed value does not fit in NUM_DIGITS digits
module sseg_scan_controller
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int DATA_W      = 32,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     writeback,
  input  logic                  write_ready,
  input  logic                  blank_en,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic [NUM_DIGITS-1:0] SSEG_AN,
  output logic [7:0]            SSEG_CA,
  output logic                  busy,
  output logic                  overflow
);

  localparam int DISP_W = 4 * NUM_DIGITS;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W  = $clog2(REFRESH_DIV);

  logic [DISP_W-1:0]     disp_q;
  logic                  ovf_q;
  logic [CNT_W-1:0]      dwell_q;
  logic [IDX_W-1:0]      idx_q, msd;
  logic [NUM_DIGITS-1:0] an_q, an_next;
  logic [7:0]            ca_q, ca_next;
  logic [6:0]            seg;
  nibble_t               nib;
  logic                  blank;

`ifdef SSEG_BCD_EN
  localparam int BCD_DIGITS = bcd_digits(DATA_W, NUM_DIGITS);
  localparam int BCD_W      = 4 * BCD_DIGITS;

  logic             conv_busy, conv_done, conv_ovf;
  logic [BCD_W-1:0] conv_bcd;

  sseg_bin2bcd #(
    .DATA_W (DATA_W),
    .BCD_W  (BCD_W)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (write_ready && !conv_busy),
    .bin   (writeback),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    conv_ovf = 1'b0;
    for (int d = NUM_DIGITS; d < BCD_DIGITS; d++)
      if (conv_bcd[4*d +: 4] != 4'h0) conv_ovf = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q <= '0;
      ovf_q  <= 1'b0;
    end else if (conv_done) begin
      disp_q <= conv_bcd[DISP_W-1:0];
      ovf_q  <= conv_ovf;
    end
  end

  assign busy = conv_busy;
`else
  always_ff @(posedge clk) begin
    if (rst) disp_q <= '0;
    else if (write_ready) disp_q <= writeback[DISP_W-1:0];
  end

  assign ovf_q = 1'b0;
  assign busy  = 1'b0;
`endif

  assign overflow = ovf_q;

  // Scan timing: dwell down-counter, digit index advances at terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q <= CNT_W'(REFRESH_DIV - 1);
      idx_q   <= '0;
      an_q    <= ~(NUM_DIGITS'(1));
      ca_q    <= 8'hC0;
    end else begin
      an_q <= an_next;
      ca_q <= ca_next;
      if (dwell_q == '0) begin
        dwell_q <= CNT_W'(REFRESH_DIV - 1);
        idx_q   <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        dwell_q <= dwell_q - 1'b1;
      end
    end
  end

  always_comb begin
    // msd stays 0 for an all-zero value, so digit 0 is never blanked.
    msd = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (disp_q[4*i +: 4] != 4'h0) msd = IDX_W'(i);
    nib     = disp_q[{idx_q, 2'b00} +: 4];
    blank   = blank_en && !ovf_q && (idx_q > msd);
    seg     = ovf_q ? SEG_DASH : glyph(nib);
    an_next = ~(NUM_DIGITS'(1) << idx_q);
    if (blank) begin
      seg     = SEG_BLANK;
      an_next = '1;
    end
    ca_next = {~dp_mask[idx_q], seg};
  end

  assign SSEG_AN = an_q;
  assign SSEG_CA = ca_q;

endmodule

// File: tb/tb_sseg_scan_controller.sv
// tb_sseg_scan_controller
//   Directed bench for sseg_scan_controller with NUM_DIGITS=8, DATA_W=32,
//   REFRESH_DIV=4. Decimal-build cases are compiled in with SSEG_BCD_EN.
module tb_sseg_scan_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] writeback = '0;
  logic        write_ready = 1'b0;
  logic        blank_en = 1'b0;
  logic [7:0]  dp_mask = '0;
  logic [7:0]  SSEG_AN;
  logic [7:0]  SSEG_CA;
  logic        busy;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  sseg_scan_controller #(
    .NUM_DIGITS  (8),
    .DATA_W      (32),
    .REFRESH_DIV (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .writeback   (writeback),
    .write_ready (write_ready),
    .blank_en    (blank_en),
    .dp_mask     (dp_mask),
    .SSEG_AN     (SSEG_AN),
    .SSEG_CA     (SSEG_CA),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, capture val on the first edge after reset, then sample each slot
  // in the middle of its dwell. Slots whose expected anode is FF are blanked
  // and only the anode is checked.
  task automatic run_frame(input string tag, input logic [31:0] val, input logic blk,
                           input logic [7:0] dp, input logic [63:0] ean, input logic [63:0] eca);
    writeback = val; blank_en = blk; dp_mask = dp;
    rst = 1'b1; write_ready = 1'b0; tick();
    rst = 1'b0; write_ready = 1'b1; tick();
    write_ready = 1'b0;
    for (int e = 2; e <= 33; e++) begin
      tick();
      if (e % 4 == 3) begin
        check($sformatf("%s_an%0d", tag, (e - 3) / 4), 32'(SSEG_AN), 32'(ean[8*((e-3)/4) +: 8]));
        if (ean[8*((e-3)/4) +: 8] != 8'hFF)
          check($sformatf("%s_ca%0d", tag, (e - 3) / 4), 32'(SSEG_CA), 32'(eca[8*((e-3)/4) +: 8]));
      end
    end
  endtask

  localparam logic [63:0] WALK = 64'h7FBF_DFEF_F7FB_FDFE;

`ifdef SSEG_BCD_EN
  task automatic wait_digit(input string tag, input int k, input logic [7:0] exp_ca);
    logic [7:0] an_exp;
    an_exp = ~(8'h01 << k);
    for (int c = 0; c < 64 && SSEG_AN != an_exp; c++) tick();
    check($sformatf("%s_an%0d", tag, k), 32'(SSEG_AN), 32'(an_exp));
    check($sformatf("%s_ca%0d", tag, k), 32'(SSEG_CA), 32'(exp_ca));
  endtask

  task automatic convert(input logic [31:0] val, output int cycles);
    writeback = val; write_ready = 1'b1; tick();
    write_ready = 1'b0;
    cycles = 0;
    for (int c = 0; c < 100 && busy; c++) begin
      if (c == 10) begin writeback = 32'd9999; write_ready = 1'b1; end
      else write_ready = 1'b0;
      tick();
      cycles++;
    end
    write_ready = 1'b0;
  endtask
`endif

  initial begin
    // Reset state and scan walk
    rst = 1'b1; tick();
    rst = 1'b0;
    check("rst_an", 32'(SSEG_AN), 32'hFE);
    check("rst_ca", 32'(SSEG_CA), 32'hC0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    for (int e = 1; e <= 36; e++) begin
      tick();
      check($sformatf("walk_e%0d", e), 32'(SSEG_AN), 32'(WALK[8*(((e-1)/4)%8) +: 8]));
    end

    // Reset wins over a simultaneous capture
    writeback = 32'hFFFF_FFFF; write_ready = 1'b1; rst = 1'b1; tick();
    rst = 1'b0; write_ready = 1'b0;
    check("prio_an", 32'(SSEG_AN), 32'hFE);
    tick(); tick();
    check("prio_ca", 32'(SSEG_CA), 32'hC0);

`ifndef SSEG_BCD_EN
    run_frame("a5_blank", 32'h0000_00A5, 1'b1, 8'h00, 64'hFFFF_FFFF_FFFF_FDFE, 64'h0000_0000_0000_8892);
    run_frame("dp2", 32'h0, 1'b0, 8'h04, WALK, 64'hC0C0_C0C0_C040_C0C0);
    run_frame("zero_blank", 32'h0, 1'b1, 8'h00, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_00C0);
    run_frame("inner_zero", 32'h1234_0F00, 1'b1, 8'h00, WALK, 64'hF9A4_B099_C08E_C0C0);
    run_frame("hex_dp", 32'h89AB_CDEF, 1'b0, 8'hFF, WALK, 64'h0010_0803_4621_060E);
    check("hex_busy", 32'(busy), 32'h0);
    check("hex_ovf", 32'(overflow), 32'h0);
`else
    begin
      int cyc;
      blank_en = 1'b0; dp_mask = 8'h00;
      convert(32'd1234, cyc);
      check("bcd_busy_len", 32'(cyc), 32'd32);
      check("bcd_ovf0", 32'(overflow), 32'h0);
      wait_digit("d1234", 0, 8'h99);
      wait_digit("d1234", 1, 8'hB0);
      wait_digit("d1234", 2, 8'hA4);
      wait_digit("d1234", 3, 8'hF9);
      wait_digit("d1234", 4, 8'hC0);
      wait_digit("d1234", 7, 8'hC0);

      blank_en = 1'b1;
      convert(32'd100000000, cyc);
      check("ovf_busy_len", 32'(cyc), 32'd32);
      check("ovf_flag", 32'(overflow), 32'h1);
      for (int k = 0; k < 8; k++) wait_digit("ovf", k, 8'hBF);

      writeback = 32'd5678; write_ready = 1'b1; tick();
      write_ready = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      check("mid_busy", 32'(busy), 32'h1);
      rst = 1'b1; tick();
      rst = 1'b0;
      check("mid_rst_busy", 32'(busy), 32'h0);
      check("mid_rst_ovf", 32'(overflow), 32'h0);
      check("mid_rst_an", 32'(SSEG_AN), 32'hFE);
      check("mid_rst_ca", 32'(SSEG_CA), 32'hC0);
      for (int c = 0; c < 40; c++) tick();
      check("mid_rst_idle", 32'(busy), 32'h0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
